mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.

---
 rtl/mem_wb_stage_pkg.sv | 13 +
 rtl/mem_wb_stage_if.sv | 29 ++
 rtl/mem_wb_stage_dmem_handshake_fsm.sv | 92 +++++++++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: data-memory FSM encodings and defaults.
package mem_wb_stage_pkg;

    localparam int N_DEF        = 32;  // datapath / address width
    localparam int MAX_WAIT_DEF = 15;  // cycles dmem_req is held before abort
    localparam int CNT_W        = 4;   // width of the wait counter

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: the master raises dmem_req with dmem_we/dmem_addr/dmem_wdata
// stable and holds all of them until it samples dmem_ack high on a falling
// clock edge; dmem_ack is a single-cycle pulse and dmem_rdata is valid only in
// that cycle. An ack arriving while no request is outstanding is ignored.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic [N-1:0] dmem_rdata;
    logic         dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_wb_stage_dmem_handshake_fsm.sv
// IDLE/WAIT request sequencer for the data memory: latches the access when it
// is accepted, holds dmem_req until ack, aborts after MAX_WAIT cycles of req.
module dmem_handshake_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,   // load/store present in EX/MEM
    input  logic         we_i,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         ack_i,
    output dmem_state_e  state_o,   // current state, also used for stall
    output logic         req_o,
    output logic         we_o,
    output logic [N-1:0] addr_o,
    output logic [N-1:0] wdata_o,
    output logic         done_o,    // ack accepted at the coming edge
    output logic         error_o
);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    logic             we_q;
    logic [N-1:0]     addr_q, wdata_q;
    logic             error_q;

    // Next state: counter runs 0..MAX_WAIT-1 so req is high for exactly MAX_WAIT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (ack_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, request latches and the sticky timeout flag.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && start_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    assign state_o = state_q;
    assign req_o   = (state_q == ST_WAIT);
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign error_o = error_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: data-memory access with stall, branch/jump
// resolution with PC redirect and flush, and the write-back register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic           reg_write,
    input  logic           mem_to_reg,
    input  logic           branch_eq,
    input  logic           branch_ne,
    input  logic           jump,
    input  logic           jr_sel,
    input  logic           zero,
    input  logic [N-1:0]   pc_target,
    input  logic [N-1:0]   alu_result,
    input  logic [N-1:0]   read_data2,
    input  logic [N-1:0]   read_data1,
    input  logic [4:0]     write_reg,
    input  logic [N-1:0]   pc_4,
    input  logic [N-1:0]   inst,
    mem_wb_stage_if.master dmem,
    output logic           stall,
    output logic           redirect_valid,
    output logic [N-1:0]   redirect_pc,
    output logic           flush,
    output logic           wb_reg_write,
    output logic [4:0]     wb_write_reg,
    output logic [N-1:0]   wb_write_data,
    output logic [N-1:0]   wb_pc_4,
    output logic [N-1:0]   wb_inst,
    output logic           dmem_error
);

    dmem_state_e  fsm_state;
    logic         in_idle, mem_op, fsm_done, taken;
    logic         ctl_reg_write_q, ctl_mem_to_reg_q;
    logic [4:0]   ctl_write_reg_q;
    logic [N-1:0] ctl_pc_4_q, ctl_inst_q;
    logic         wb_reg_write_q, wb_reg_write_d;
    logic [4:0]   wb_write_reg_q, wb_write_reg_d;
    logic [N-1:0] wb_write_data_q, wb_write_data_d;
    logic [N-1:0] wb_pc_4_q, wb_pc_4_d;
    logic [N-1:0] wb_inst_q, wb_inst_d;

    dmem_handshake_fsm #(.N(N), .MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .start_i (mem_op),
        .we_i    (mem_write),
        .addr_i  (alu_result),
        .wdata_i (read_data2),
        .ack_i   (dmem.dmem_ack),
        .state_o (fsm_state),
        .req_o   (dmem.dmem_req),
        .we_o    (dmem.dmem_we),
        .addr_o  (dmem.dmem_addr),
        .wdata_o (dmem.dmem_wdata),
        .done_o  (fsm_done),
        .error_o (dmem_error)
    );

    assign in_idle = (fsm_state == ST_IDLE);
    assign mem_op  = mem_read | mem_write;

    // Stall and redirect are combinational so the flush removes the branch from
    // EX/MEM at the very edge that loads the new PC; a memory op suppresses it.
    always_comb begin
        stall          = (in_idle & mem_op) | (~in_idle & ~dmem.dmem_ack);
        taken          = (branch_eq & zero) | (branch_ne & ~zero) | jump | jr_sel;
        redirect_valid = in_idle & ~mem_op & taken;
        flush          = redirect_valid;
        redirect_pc    = jr_sel ? read_data1 : pc_target;
    end

    // Capture write-back controls of a memory op when it is accepted; stores never write.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ctl_reg_write_q  <= 1'b0;
            ctl_mem_to_reg_q <= 1'b0;
            ctl_write_reg_q  <= '0;
            ctl_pc_4_q       <= '0;
            ctl_inst_q       <= '0;
        end else if (in_idle && mem_op) begin
            ctl_reg_write_q  <= reg_write & ~mem_write;
            ctl_mem_to_reg_q <= mem_to_reg;
            ctl_write_reg_q  <= write_reg;
            ctl_pc_4_q       <= pc_4;
            ctl_inst_q       <= inst;
        end
    end

    // MEM/WB next value: bubble with held data unless an instruction completes.
    always_comb begin
        wb_reg_write_d  = 1'b0;
        wb_write_reg_d  = wb_write_reg_q;
        wb_write_data_d = wb_write_data_q;
        wb_pc_4_d       = wb_pc_4_q;
        wb_inst_d       = wb_inst_q;
        if (in_idle && !mem_op) begin
            wb_reg_write_d  = reg_write;
            wb_write_reg_d  = write_reg;
            wb_write_data_d = alu_result;
            wb_pc_4_d       = pc_4;
            wb_inst_d       = inst;
        end else if (fsm_done) begin
            wb_reg_write_d  = ctl_reg_write_q;
            wb_write_reg_d  = ctl_write_reg_q;
            wb_write_data_d = ctl_mem_to_reg_q ? dmem.dmem_rdata : dmem.dmem_addr;
            wb_pc_4_d       = ctl_pc_4_q;
            wb_inst_d       = ctl_inst_q;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= '0;
            wb_write_data_q <= '0;
            wb_pc_4_q       <= '0;
            wb_inst_q       <= '0;
        end else begin
            wb_reg_write_q  <= wb_reg_write_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_write_data_q <= wb_write_data_d;
            wb_pc_4_q       <= wb_pc_4_d;
            wb_inst_q       <= wb_inst_d;
        end
    end

    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_write_data = wb_write_data_q;
    assign wb_pc_4       = wb_pc_4_q;
    assign wb_inst       = wb_inst_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a write-back scoreboard.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int W = 5 + 3 * 32;  // {write_reg, write_data, pc_4, inst}

  logic        clk, reset;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic        branch_eq, branch_ne, jump, jr_sel, zero;
  logic [31:0] pc_target, alu_result, read_data2, read_data1, pc_4, inst;
  logic [4:0]  write_reg;
  logic        stall, redirect_valid, flush, wb_reg_write, dmem_error;
  logic [31:0] redirect_pc, wb_write_data, wb_pc_4, wb_inst;
  logic [4:0]  wb_write_reg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [31:0]  cur_pc = 32'h0000_1000;

  mem_wb_stage_if dmem_if ();

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .jr_sel(jr_sel), .zero(zero),
    .pc_target(pc_target), .alu_result(alu_result), .read_data2(read_data2), .read_data1(read_data1),
    .write_reg(write_reg), .pc_4(pc_4), .inst(inst),
    .dmem(dmem_if),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .wb_pc_4(wb_pc_4), .wb_inst(wb_inst), .dmem_error(dmem_error)
  );

  // clock / reset: state changes on the falling edge
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every registered write-back must match the oldest expected one
  always @(negedge clk) begin
    #1;
    if (reset === 1'b1 && wb_reg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write reg %0d data %h, required no write", wb_write_reg, wb_write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wb_write_reg, wb_write_data, wb_pc_4, wb_inst} !== mon_exp) begin
          errors++;
          $display("FAIL wb_record: got %h, required %h", {wb_write_reg, wb_write_data, wb_pc_4, wb_inst}, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    branch_eq = 0; branch_ne = 0; jump = 0; jr_sel = 0; zero = 0;
    pc_target = 0; alu_result = 0; read_data2 = 0; read_data1 = 0;
    write_reg = 0; pc_4 = 0; inst = 0;
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
  endtask

  task automatic next_pc();
    cur_pc = cur_pc + 32'd4;
    pc_4   = cur_pc;
    inst   = $urandom;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    reg_write = 1; write_reg = 5'd3; alu_result = 32'hFFFF_0001; pc_4 = 32'h44; inst = 32'h55;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wb_reg_write, wb_write_reg, wb_write_data, wb_pc_4, wb_inst} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got %h, required 0", {wb_reg_write, wb_write_reg, wb_write_data, wb_pc_4, wb_inst});
    end
    checks++;
    if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata, dmem_error} !== '0) begin
      errors++;
      $display("FAIL reset_dmem: got req %b we %b addr %h wdata %h err %b, required all 0",
               dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata, dmem_error);
    end
    checks++;
    if ({stall, redirect_valid, flush} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got stall/redirect/flush %b, required 000", {stall, redirect_valid, flush});
    end
    clear_inputs();
    @(posedge clk);
    reset = 1;
  endtask

  task automatic alu_op(input string name, input logic [4:0] wreg, input logic [31:0] data);
    @(posedge clk);
    clear_inputs();
    next_pc();
    reg_write = 1; write_reg = wreg; alu_result = data;
    exp_q.push_back({wreg, data, pc_4, inst});
    #2;
    checks++;
    if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall: got stall %b redirect %b, required 0 0", name, stall, redirect_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_reg_write !== 1'b1 || wb_write_reg !== wreg || wb_write_data !== data) begin
      errors++;
      $display("FAIL %s_wb: got we %b reg %0d data %h, required 1 %0d %h", name, wb_reg_write, wb_write_reg,
               wb_write_data, wreg, data);
    end
    clear_inputs();
  endtask

  task automatic run_mem_op(input string name, input logic is_store, input logic with_jump,
                            input logic [4:0] wreg, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack_k,
                            input logic [4:0] hold_reg, input logic [31:0] hold_data);
    int n_stall;
    n_stall = 0;
    @(posedge clk);
    clear_inputs();
    next_pc();
    mem_read = ~is_store; mem_write = is_store; reg_write = 1; mem_to_reg = ~is_store;
    write_reg = wreg; alu_result = addr; read_data2 = wdata;
    jump = with_jump; pc_target = 32'h0BAD_0000;
    if (!is_store) exp_q.push_back({wreg, rdata, pc_4, inst});
    for (int c = 0; c <= ack_k + 1; c++) begin
      if (c > 0) @(posedge clk);
      if (c == ack_k + 1) begin
        dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = rdata;
      end
      #2;
      if (stall === 1'b1) n_stall++;
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL %s_redirect: got redirect %b flush %b in cycle %0d, required 0 0", name, redirect_valid, flush, c);
      end
      @(negedge clk);
      #1;
      if (c <= ack_k) begin
        checks++;
        if (dmem_if.dmem_req !== 1'b1 || dmem_if.dmem_we !== is_store || dmem_if.dmem_addr !== addr ||
            dmem_if.dmem_wdata !== wdata) begin
          errors++;
          $display("FAIL %s_bus: got req %b we %b addr %h wdata %h after edge %0d, required 1 %b %h %h", name,
                   dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata, c, is_store, addr, wdata);
        end
        checks++;
        if (wb_reg_write !== 1'b0 || wb_write_reg !== hold_reg || wb_write_data !== hold_data) begin
          errors++;
          $display("FAIL %s_hold: got we %b reg %0d data %h after edge %0d, required 0 %0d %h", name, wb_reg_write,
                   wb_write_reg, wb_write_data, c, hold_reg, hold_data);
        end
      end
    end
    checks++;
    if (dmem_if.dmem_req !== 1'b0 || wb_reg_write !== ~is_store) begin
      errors++;
      $display("FAIL %s_done: got req %b wb_we %b, required 0 %b", name, dmem_if.dmem_req, wb_reg_write, ~is_store);
    end
    if (!is_store) begin
      checks++;
      if (wb_write_data !== rdata || wb_write_reg !== wreg) begin
        errors++;
        $display("FAIL %s_data: got reg %0d data %h, required %0d %h", name, wb_write_reg, wb_write_data, wreg, rdata);
      end
    end
    checks++;
    if (n_stall != ack_k + 1) begin
      errors++;
      $display("FAIL %s_stall_len: got %0d cycles, required %0d", name, n_stall, ack_k + 1);
    end
    clear_inputs();
  endtask

  task automatic test_branch(input string name, input logic beq, input logic bne, input logic jmp,
                             input logic jr, input logic z, input logic [31:0] tgt, input logic [31:0] rd1,
                             input logic exp_taken, input logic [31:0] exp_pc);
    @(posedge clk);
    clear_inputs();
    next_pc();
    branch_eq = beq; branch_ne = bne; jump = jmp; jr_sel = jr; zero = z;
    pc_target = tgt; read_data1 = rd1;
    #2;
    checks++;
    if (redirect_valid !== exp_taken || flush !== exp_taken || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_taken: got redirect %b flush %b stall %b, required %b %b 0", name, redirect_valid, flush,
               stall, exp_taken, exp_taken);
    end
    if (exp_taken) begin
      checks++;
      if (redirect_pc !== exp_pc) begin
        errors++;
        $display("FAIL %s_pc: got %h, required %h", name, redirect_pc, exp_pc);
      end
    end
    @(negedge clk);
    #1;
    clear_inputs();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || wb_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got redirect %b flush %b wb_we %b after flush, required 0 0 0", name, redirect_valid,
               flush, wb_reg_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  r;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      clear_inputs();
      next_pc();
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      reg_write = 1; write_reg = r; alu_result = d;
      exp_q.push_back({r, d, pc_4, inst});
      @(negedge clk);
      #1;
      checks++;
      if (wb_reg_write !== 1'b1 || wb_write_data !== d) begin
        errors++;
        $display("FAIL b2b_%0d: got we %b data %h, required 1 %h", i, wb_reg_write, wb_write_data, d);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random_loads();
    logic [4:0]  r, lr;
    logic [31:0] d, a, rd;
    for (int i = 0; i < 4; i++) begin
      r  = 5'($urandom_range(1, 31));
      lr = 5'($urandom_range(1, 31));
      d  = $urandom; a = $urandom; rd = $urandom;
      alu_op("rand_alu", r, d);
      run_mem_op("rand_load", 1'b0, 1'b0, lr, a, 32'h0, rd, int'($urandom_range(0, 6)), r, d);
    end
  endtask

  task automatic test_timeout();
    int req_cnt;
    req_cnt = 0;
    @(posedge clk);
    checks++;
    if (dmem_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre_err: got %b, required 0", dmem_error);
    end
    clear_inputs();
    next_pc();
    mem_read = 1; reg_write = 1; mem_to_reg = 1; write_reg = 5'd9; alu_result = 32'h80;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      #1;
      checks++;
      if (wb_reg_write !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wb: got wb_we %b at edge %0d, required 0", wb_reg_write, e);
      end
      if (dmem_if.dmem_req === 1'b1) req_cnt++;
      else begin
        clear_inputs();
        break;
      end
    end
    #1;
    checks++;
    if (req_cnt != MAX_WAIT_DEF || dmem_error !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got req cycles %0d err %b stall %b, required %0d 1 0", req_cnt, dmem_error,
               stall, MAX_WAIT_DEF);
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dmem_error !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: got err %b wb_we %b, required 1 0", dmem_error, wb_reg_write);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk);
    clear_inputs();
    next_pc();
    mem_read = 1; reg_write = 1; mem_to_reg = 1; write_reg = 5'd10; alu_result = 32'h88;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dmem_if.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_req: got %b, required 1", dmem_if.dmem_req);
    end
    #2;
    reset = 0;
    clear_inputs();
    #1;
    checks++;
    if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_error} !== '0) begin
      errors++;
      $display("FAIL rstwait_dmem: got req %b we %b addr %h err %b, required all 0", dmem_if.dmem_req,
               dmem_if.dmem_we, dmem_if.dmem_addr, dmem_error);
    end
    checks++;
    if ({wb_reg_write, wb_write_reg, wb_write_data, wb_pc_4, wb_inst} !== '0) begin
      errors++;
      $display("FAIL rstwait_wb: got %h, required 0", {wb_reg_write, wb_write_reg, wb_write_data, wb_pc_4, wb_inst});
    end
    @(posedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wb_reg_write !== 1'b0 || dmem_if.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_after: got wb_we %b req %b, required 0 0", wb_reg_write, dmem_if.dmem_req);
    end
  endtask

  initial begin
    test_reset();
    alu_op("alu", 5'd5, 32'h10);
    run_mem_op("load", 1'b0, 1'b0, 5'd7, 32'h40, 32'h0, 32'hDEAD_BEEF, 3, 5'd5, 32'h10);
    run_mem_op("store", 1'b1, 1'b0, 5'd8, 32'h44, 32'h1234, 32'h0, 0, 5'd7, 32'hDEAD_BEEF);
    test_branch("bne_taken", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h80);
    test_branch("beq_not", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h90, 32'h0, 1'b0, 32'h0);
    test_branch("beq_taken", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 32'h0, 1'b1, 32'hA0);
    test_branch("bne_not", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB0, 32'h0, 1'b0, 32'h0);
    test_branch("jump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC0, 32'h400, 1'b1, 32'hC0);
    test_branch("jr_over_j", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h200, 1'b1, 32'h200);
    alu_op("pre_prio", 5'd12, 32'h5A5A);
    run_mem_op("load_jump", 1'b0, 1'b1, 5'd13, 32'h60, 32'h0, 32'hCAFE_F00D, 1, 5'd12, 32'h5A5A);
    test_back_to_back();
    test_random_loads();
    test_timeout();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
